// File: rtl/hazard_fwd_unit_if.sv
// Decode-side control bundle between the pipeline control unit and the hazard/forwarding unit.
// The control unit owns the master side; hazard_fwd_unit sits on the slave side.
interface hazard_fwd_unit_if #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);

  // Decode stage information, presented once at issue
  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src_reg;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [REG_AW-1:0]           id_dst_reg;
  logic                        id_reg_write;
  logic                        id_mem_read;

  // Pipeline control inputs
  logic                        flush;
  logic                        mem_busy;

  // Hazard and forwarding results
  logic                        stall_id;
  logic                        freeze;
  logic [2*NUM_SRC-1:0]        ex_fwd_sel;
  logic [NUM_SRC-1:0]          id_wb_bypass;
  logic [CNT_W-1:0]            load_use_cnt;

  modport master (
    output id_valid,
    output id_src_reg,
    output id_src_used,
    output id_dst_reg,
    output id_reg_write,
    output id_mem_read,
    output flush,
    output mem_busy,
    input  stall_id,
    input  freeze,
    input  ex_fwd_sel,
    input  id_wb_bypass,
    input  load_use_cnt
  );

  modport slave (
    input  id_valid,
    input  id_src_reg,
    input  id_src_used,
    input  id_dst_reg,
    input  id_reg_write,
    input  id_mem_read,
    input  flush,
    input  mem_busy,
    output stall_id,
    output freeze,
    output ex_fwd_sel,
    output id_wb_bypass,
    output load_use_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Tracks a shadow copy of EX/MEM/WB control captured from decode at issue, and derives EX
// forwarding selects, ID write-through bypass, load-use stalls and the memory-busy freeze.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned R0_ZERO = 0,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_unit_if.slave hz_io
);

  localparam int unsigned SrcW = NUM_SRC * REG_AW;

  // Forwarding select encodings
  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelWb  = 2'b10;

  // ---------------------------------------------------------------------------------------------
  // Shadow pipeline state
  // ---------------------------------------------------------------------------------------------

  // EX shadow: full control plus source operands so EX forwarding can be resolved here
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_dst_q,   ex_dst_d;
  logic              ex_rw_q,    ex_rw_d;
  logic              ex_ld_q,    ex_ld_d;
  logic [SrcW-1:0]   ex_src_q,   ex_src_d;
  logic [NUM_SRC-1:0] ex_used_q, ex_used_d;

  // MEM shadow
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_dst_q;
  logic              mem_rw_q;
  logic              mem_ld_q;

  // WB shadow
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_dst_q;
  logic              wb_rw_q;
  logic              wb_ld_q;

  // Load-use stall counter
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // ---------------------------------------------------------------------------------------------
  // Match helper
  // ---------------------------------------------------------------------------------------------

  // A stage "writes r" when it holds a live register-writing instruction targeting r.
  // With R0_ZERO set, r0 is hardwired and never participates in a hazard.
  function automatic logic reg_hit(input logic              valid,
                                   input logic              reg_write,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] r);
    logic r_ok;
    r_ok    = (R0_ZERO == 0) || (r != '0);
    reg_hit = valid & reg_write & (dst == r) & r_ok;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Per-source hazard detection
  // ---------------------------------------------------------------------------------------------

  logic [NUM_SRC-1:0]   lu_hit;
  logic [NUM_SRC-1:0]   ex_mem_hit;
  logic [NUM_SRC-1:0]   ex_wb_hit;
  logic [NUM_SRC-1:0]   wb_bypass;
  logic [2*NUM_SRC-1:0] fwd_sel;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] id_src;
    logic [REG_AW-1:0] ex_src;

    assign id_src = hz_io.id_src_reg[k*REG_AW +: REG_AW];
    assign ex_src = ex_src_q[k*REG_AW +: REG_AW];

    // Decode source k depends on the instruction currently in EX
    assign lu_hit[k] = hz_io.id_src_used[k] & reg_hit(ex_valid_q, ex_rw_q, ex_dst_q, id_src);

    // A load in MEM has no result yet, so it cannot source an EX/MEM forward
    assign ex_mem_hit[k] = ex_used_q[k] & ~mem_ld_q
                         & reg_hit(mem_valid_q, mem_rw_q, mem_dst_q, ex_src);
    assign ex_wb_hit[k]  = ex_used_q[k] & reg_hit(wb_valid_q, wb_rw_q, wb_dst_q, ex_src);

    // Write-through of the WB result into decode; the datapath prefers EX forwards over this
    assign wb_bypass[k] = hz_io.id_valid & reg_hit(wb_valid_q, wb_rw_q, wb_dst_q, id_src);

    // Younger MEM result wins over the older WB result
    assign fwd_sel[2*k +: 2] = ex_mem_hit[k] ? SelMem :
                               ex_wb_hit[k]  ? SelWb  : SelRf;
  end

  // ---------------------------------------------------------------------------------------------
  // Stall / freeze control
  // ---------------------------------------------------------------------------------------------

  logic load_use;
  logic lu_stall;
  logic issue;
  logic advance;

  assign load_use = hz_io.id_valid & ex_ld_q & (|lu_hit);
  // A flush kills the consumer, so there is nothing left to stall for
  assign lu_stall = load_use & ~hz_io.flush;
  assign issue    = hz_io.id_valid & ~hz_io.flush & ~load_use;
  assign advance  = ~hz_io.mem_busy;

  // Combinational outputs, forced quiet while reset is asserted
  always_comb begin
    hz_io.stall_id     = 1'b0;
    hz_io.freeze       = 1'b0;
    if (!rst) begin
      hz_io.stall_id = lu_stall | hz_io.mem_busy;
      hz_io.freeze   = hz_io.mem_busy;
    end
    hz_io.ex_fwd_sel   = fwd_sel;
    hz_io.id_wb_bypass = wb_bypass;
    hz_io.load_use_cnt = cnt_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------------------------

  // Next EX shadow: decode fields on issue, otherwise a bubble. A bubble also clears the used
  // bits so its (meaningless) sources never request a forward.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_dst_d   = hz_io.id_dst_reg;
    ex_rw_d    = hz_io.id_reg_write;
    ex_ld_d    = hz_io.id_mem_read;
    ex_src_d   = hz_io.id_src_reg;
    ex_used_d  = '0;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_used_d  = hz_io.id_src_used;
    end
  end

  // Saturating load-use stall counter
  always_comb begin
    cnt_d = cnt_q;
    if (lu_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------

  // Shadow pipeline and counter; everything holds while the memory is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_used_q   <= '0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      cnt_q       <= '0;
    end else if (advance) begin
      ex_valid_q  <= ex_valid_d;
      ex_dst_q    <= ex_dst_d;
      ex_rw_q     <= ex_rw_d;
      ex_ld_q     <= ex_ld_d;
      ex_src_q    <= ex_src_d;
      ex_used_q   <= ex_used_d;

      mem_valid_q <= ex_valid_q;
      mem_dst_q   <= ex_dst_q;
      mem_rw_q    <= ex_rw_q;
      mem_ld_q    <= ex_ld_q;

      wb_valid_q  <= mem_valid_q;
      wb_dst_q    <= mem_dst_q;
      wb_rw_q     <= mem_rw_q;
      wb_ld_q     <= mem_ld_q;

      cnt_q       <= cnt_d;
    end
  end

  // The WB load flag is tracked for completeness of the shadow; nothing downstream needs it.
  logic unused_wb_ld;
  assign unused_wb_ld = wb_ld_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard detection and forwarding unit for the 5-stage pipeline. Replaces the flat compare-only forwarding logic.
- Keeps its own shadow copy of the EX, MEM and WB stage control: destination, reg-write, load flag and source registers. Decode supplies this information once, at issue.
- From the shadows it generates per-source EX forwarding selects, ID write-through bypass, load-use stalls and a memory-busy freeze. A saturating load-use stall counter is also provided.

Parameters:
- REG_AW, 4, register address width.
- NUM_SRC, 2, source operands per instruction.
- R0_ZERO, 0. When 1, register 0 never matches (no forward, no bypass, no stall).
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  a valid instruction is in decode.
- id_src_reg  in  NUM_SRC*REG_AW  decode source registers; source k is at [k*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  source k is actually read.
- id_dst_reg  in  REG_AW  decode destination register.
- id_reg_write  in  1  decode instruction writes the register file.
- id_mem_read  in  1  decode instruction is a load.
- flush  in  1  squash the decode instruction (taken branch/jump).
- mem_busy  in  1  data memory not ready.
- stall_id  out  1  hold PC and IF/ID; inject a bubble into EX.
- freeze  out  1  hold all pipeline registers.
- ex_fwd_sel  out  2*NUM_SRC  per EX source: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 never driven.
- id_wb_bypass  out  NUM_SRC  per decode source: take the WB write data instead of the register-file read.
- load_use_cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Shadow stages:
  - EX holds: valid, dst, reg_write, mem_read, src[NUM_SRC], used[NUM_SRC].
  - MEM and WB hold: valid, dst, reg_write, mem_read.
- Reset: while rst is high, all shadow valids are cleared and load_use_cnt is cleared, both on the clock edge. stall_id=0 and freeze=0 are forced combinationally. With empty shadows, ex_fwd_sel=0 and id_wb_bypass=0.
- Match definition: "X matches source r" means X.valid & X.reg_write & (X.dst==r). When R0_ZERO=1, r must also be nonzero. For EX forwarding and load-use, the source's used bit must also be set.
- load_use = id_valid & (EX shadow is a load) & EX matches any used decode source.
- Output equations:
  - stall_id = (load_use & ~flush) | mem_busy.
  - freeze = mem_busy.
  - Both outputs are combinational, with zero-cycle latency.
- ex_fwd_sel[k]:
  - 01 if the MEM shadow matches EX src k and is not a load.
  - Else 10 if the WB shadow matches EX src k.
  - Else 00.
  - MEM (younger) has priority over WB. A MEM-stage load matching EX yields 10 or 00, never 01; this case is unreachable because of the load-use stall.
- id_wb_bypass[k] = id_valid & WB matches decode src k. This is independent of the EX/MEM forwards; the datapath gives EX forwarding priority.
- Advance, on each rising edge while not rst:
  - If freeze: all shadows hold; flush and load_use are ignored for shadow update; the counter does not increment.
  - Else: WB<=MEM, MEM<=EX.
  - EX <= bubble (valid=0) if flush | load_use | ~id_valid; otherwise EX <= the decode fields with valid=1.
- Flush and load_use in the same cycle: flush wins, stall_id=0, EX gets a bubble, the counter does not increment.
- A flush asserted during freeze must be held by the control unit until freeze drops. This block does not latch it.
- Counter: increments by 1 on each non-frozen cycle with load_use & ~flush. It saturates at all-ones and does not wrap.
- A back-to-back load-use stall cannot repeat: after one bubble the load sits in MEM and the consumer forwards from WB (10) on the next EX cycle.

Test Plan:
1. ALU chain. Issue ADD r3 (id_reg_write=1), then SUB using src0=r3 (REGS default).
   - Cycle after SUB enters EX: ex_fwd_sel[1:0]=01.
   - One cycle later, for an independent third instruction using r3 in src1: ex_fwd_sel[3:2]=10.
2. Load-use. LD r5 issued, next instruction reads r5 in src1.
   - stall_id=1 for exactly one cycle; EX shadow is a bubble.
   - Consumer then enters EX with ex_fwd_sel[3:2]=10.
   - load_use_cnt goes 0→1.
3. Flush vs stall. Load in EX, decode reads its dst, flush=1 in the same cycle.
   - stall_id=0; EX becomes a bubble; load_use_cnt unchanged.
4. Freeze. mem_busy=1 for 3 cycles with a load-use pending.
   - freeze=1 and stall_id=1 for all 3 cycles; shadows unchanged; counter unchanged.
   - After release: exactly one load-use stall cycle, counter +1.
5. R0 and WB bypass.
   - R0_ZERO=1, write r0 then read r0: ex_fwd_sel=00, no stall.
   - R0_ZERO=0, same sequence: ex_fwd_sel=01.
   - Instruction in WB writing r7 while decode reads r7 in src0: id_wb_bypass[0]=1.
6. Reset mid-operation. rst=1 with mem_busy=1 and a load in EX.
   - stall_id=0 and freeze=0 immediately.
   - After the edge: all selects 00, load_use_cnt=0.
   - Saturation check: force CNT_W=2 and cause 5 stalls; counter reads 3.
